corr_dump_buf: RTL and testbench
================================

Name: corr_dump_buf

Overview:
Downstream stage of the correlator channel. On each dump strobe (the cycle the channel's IQ snapshot registers are valid, i.e. one cycle after epoch_pulse), it snapshots all packed IQ words plus the epoch number. It serialises them as one framed record into a FIFO and presents them on a valid/ready stream for the DMA/bus reader. Frames are atomic: a dump is accepted whole or dropped and counted, never truncated.

Parameters:
N_INP, 2, correlator inputs per channel
DELAYS, 1, early/late taps per side; taps per input = 2*DELAYS+1
EPOCH_W, 16, epoch number width; must be <= 24
FIFO_DEPTH, 64, FIFO words; power of 2, >= FRAME (FRAME = N_INP*(2*DELAYS+1)+1; default 7)

Ports:
clk  in  1  single clock (adc clock domain)
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush/restart
dump  in  1  one-cycle snapshot strobe
iq_in  in  32*NW  packed IQ words; NW = N_INP*(2*DELAYS+1); word k = bits [32k+31:32k], k = inp*(2*DELAYS+1)+dly
epoch_in  in  EPOCH_W  epoch number sampled with dump
m_data  out  32  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  marks final word of a frame
frame_irq  out  1  one-cycle pulse per completed frame
drop_cnt  out  16  dropped-frame counter, saturating
level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1): FSM IDLE; FIFO empty; m_valid=0, m_last=0, m_data=0, frame_irq=0, drop_cnt=0, level=0, seq=0.
- Frame format: word 0 is the header {seq[7:0], zero pad, epoch[EPOCH_W-1:0]}, with seq in [31:24] and epoch in [EPOCH_W-1:0]. Words 1..NW are iq_in word 0..NW-1 in index order. Each FIFO entry carries a last tag; the tag is set only on IQ word NW-1.
- FSM states: IDLE, HDR, DATA.
  - IDLE: on dump with free = FIFO_DEPTH-level >= FRAME, latch iq_in and epoch_in into a shadow register and go to HDR. On dump with free < FRAME, stay IDLE and increment drop_cnt.
  - HDR: write header (one cycle), then go to DATA with word index 0.
  - DATA: write one IQ word per cycle. After index NW-1, increment seq (8-bit, wraps 255->0) and return to IDLE.
- Space is reserved at acceptance, so FIFO writes never stall. Reads during the frame only add space.
- Timing, dump sampled in cycle T:
  - header written at the T+1 edge and readable (m_valid, FIFO empty beforehand) in T+2;
  - IQ word k written at the edge of T+2+k;
  - frame_irq pulses in cycle T+NW+2, the cycle the last word first becomes readable.
- dump while in HDR or DATA: dropped, drop_cnt+1; the frame in progress is unaffected. A dump in the same cycle as the FSM returns to IDLE is also dropped.
- drop_cnt saturates at 0xFFFF.
- Stream: FIFO is first-word-fall-through. m_valid = !empty. m_data/m_last are stable while m_valid && !m_ready. A word pops on m_valid && m_ready. Simultaneous read and write keeps level unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Full is distinguished from empty by the extra level bit. The level=FIFO_DEPTH case is reachable and must not be misread as empty.
- clear (sync, highest priority after rst): same state as reset. A dump in the same cycle is ignored and not counted. An in-progress frame is discarded, with no irq.
- Reset mid-frame: the partial frame is lost; output resumes clean at the next accepted dump.

Test Plan:
1. NW=6, m_ready=1, dump at T with epoch 0x1234, iq_in word k = 0xA0000000+k -> header 0x00001234 valid at T+2, words 0xA0000000..0xA0000005 follow on consecutive cycles, m_last only on 0xA0000005, frame_irq at T+8.
2. m_ready=0, dumps every 10 cycles, depth 64 -> 9 frames accepted (63 words), 10th dropped, drop_cnt=1, level=63. Raise m_ready -> 63 words drain, seq in headers 0..8.
3. Dump, then a second dump 3 cycles later -> second dropped, drop_cnt=1, and the first frame is intact. A third dump at T+8 (FSM back in IDLE) -> accepted, seq=1.
4. Random m_ready at 30% -> all words are delivered in order with no duplication, and m_data stays stable while stalled.
5. Assert clear mid-frame together with a dump -> level=0, m_valid=0, drop_cnt=0, no frame_irq. The next dump yields seq=0.
6. 256 accepted frames -> seq wraps 0xFF->0x00. Force 65540 drops -> drop_cnt holds 0xFFFF.

Source files
------------

// File: rtl/corr_dump_buf.sv
// Correlator dump buffer: snapshots IQ words plus epoch on each dump strobe and streams
// them as atomic framed records (header + NW words) through a first-word-fall-through FIFO.
module corr_dump_buf #(
    parameter  int N_INP      = 2,
    parameter  int DELAYS     = 1,
    parameter  int EPOCH_W    = 16,
    parameter  int FIFO_DEPTH = 64,
    localparam int NW         = N_INP * (2 * DELAYS + 1),
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               dump,
    input  logic [32*NW-1:0]   iq_in,
    input  logic [EPOCH_W-1:0] epoch_in,
    output logic [31:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               frame_irq,
    output logic [15:0]        drop_cnt,
    output logic [LW-1:0]      level
);
    localparam int FRAME = NW + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IW    = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } entry_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [7:0]              seq_q;
    logic [EPOCH_W-1:0]      epoch_q;
    logic [NW-1:0][31:0]     iq_q;
    logic [15:0]             drop_q;
    logic                    irq_q;
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q, level_d;
    entry_t                  mem [FIFO_DEPTH];

    logic   empty, has_room, accept, drop_evt, wr_en, rd_en, last_word;
    entry_t wr_entry, rd_entry;

    // Room for a whole frame is checked once, at acceptance; the FSM then writes unthrottled.
    assign empty     = (level_q == '0);
    assign has_room  = (level_q <= LW'(FIFO_DEPTH - FRAME));
    assign accept    = dump && (state_q == IDLE) && has_room;
    assign drop_evt  = dump && !accept;
    assign wr_en     = (state_q != IDLE);
    assign rd_en     = !empty && m_ready;
    assign last_word = (state_q == DATA) && (idx_q == IW'(NW - 1));

    always_comb begin
        wr_entry = '0;
        if (state_q == HDR) begin
            wr_entry.data[31:24]        = seq_q;
            wr_entry.data[EPOCH_W-1:0]  = epoch_q;
        end else begin
            wr_entry.data = iq_q[idx_q];
            wr_entry.last = last_word;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            seq_q    <= '0;
            epoch_q  <= '0;
            iq_q     <= '0;
            drop_q   <= '0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            irq_q   <= last_word;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            case (state_q)
                IDLE: if (accept) begin
                    iq_q    <= iq_in;
                    epoch_q <= epoch_in;
                    state_q <= HDR;
                end
                HDR: begin
                    idx_q   <= '0;
                    state_q <= DATA;
                end
                DATA: begin
                    if (last_word) begin
                        seq_q   <= seq_q + 8'd1;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end

    // Gate the head so the stream reads zero while empty; the head cannot be overwritten
    // while occupied because reserved space keeps wr_ptr off rd_ptr.
    assign rd_entry  = mem[rd_ptr_q];
    assign m_valid   = !empty;
    assign m_data    = empty ? 32'd0 : rd_entry.data;
    assign m_last    = !empty && rd_entry.last;
    assign frame_irq = irq_q;
    assign drop_cnt  = drop_q;
    assign level     = level_q;

endmodule

// File: tb/tb_corr_dump_buf.sv
// Directed bench for corr_dump_buf: framing, timing, drops, full FIFO, clear, wrap/saturation.
module tb_corr_dump_buf;
    localparam int NW = 6;
    localparam int LW = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              dump = 1'b0;
    logic [32*NW-1:0]  iq_in = '0;
    logic [15:0]       epoch_in = '0;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic              frame_irq;
    logic [15:0]       drop_cnt;
    logic [LW-1:0]     level;

    int checks = 0;
    int fails  = 0;
    int irq_n  = 0;
    logic [7:0]  mseq = 8'd0;
    logic [32:0] got[$];
    logic [32:0] expq[$];
    bit          stab_en = 1'b0;
    bit          pend = 1'b0;
    logic [32:0] stall_val = '0;

    corr_dump_buf dut (
        .clk(clk), .rst(rst), .clear(clear), .dump(dump), .iq_in(iq_in),
        .epoch_in(epoch_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .frame_irq(frame_irq), .drop_cnt(drop_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) got.push_back({m_last, m_data});
            if (frame_irq) irq_n++;
            if (stab_en && pend) chk("stable", {m_valid, m_last, m_data}, {1'b1, stall_val});
            pend      = stab_en && m_valid && !m_ready;
            stall_val = {m_last, m_data};
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_iq(input logic [15:0] ep, input logic [31:0] base);
        epoch_in = ep;
        for (int k = 0; k < NW; k++) iq_in[32*k +: 32] = base + 32'(k);
    endtask

    task automatic exp_frame(input logic [15:0] ep, input logic [31:0] base);
        expq.push_back({1'b0, mseq, 8'h00, ep});
        for (int k = 0; k < NW; k++) expq.push_back({k == NW - 1, base + 32'(k)});
        mseq = mseq + 8'd1;
    endtask

    task automatic do_dump(input logic [15:0] ep, input logic [31:0] base, input bit acc);
        set_iq(ep, base);
        dump = 1'b1;
        if (acc) exp_frame(ep, base);
        tick();
        dump = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; dump = 1'b0; clear = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mseq = 8'd0;
        got.delete(); expq.delete();
        irq_n = 0;
        tick();
    endtask

    task automatic wait_q(input string tag, input int n);
        int b = 0;
        while (got.size() < n && b < 3000) begin tick(); b++; end
        chk({tag, "_timeout"}, 64'(b < 3000), 64'd1);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_len"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++) chk(tag, 64'(got[i]), 64'(expq[i]));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_irq", 64'(frame_irq), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single frame timing
        m_ready = 1'b1;
        do_dump(16'h1234, 32'hA000_0000, 1'b0);
        chk("t1_T1_valid", 64'(m_valid), 64'd0);
        tick();
        chk("t1_hdr_valid", 64'(m_valid), 64'd1);
        chk("t1_hdr_data", 64'(m_data), 64'h0000_1234);
        chk("t1_hdr_last", 64'(m_last), 64'd0);
        for (int k = 0; k < NW; k++) begin
            tick();
            chk("t1_w_valid", 64'(m_valid), 64'd1);
            chk("t1_w_data", 64'(m_data), 64'(32'hA000_0000 + 32'(k)));
            chk("t1_w_last", 64'(m_last), 64'(k == NW - 1));
            chk("t1_w_irq", 64'(frame_irq), 64'(k == NW - 1));
        end
        tick();
        chk("t1_end_valid", 64'(m_valid), 64'd0);
        chk("t1_end_level", 64'(level), 64'd0);
        chk("t1_end_irq", 64'(frame_irq), 64'd0);

        // 2: fill with m_ready=0, drop on overflow, then reach a completely full FIFO
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_dump(16'h0100 + 16'(i), 32'h1000_0000 + (32'(i) << 8), i < 9);
            for (int j = 0; j < 9; j++) tick();
        end
        chk("t2_drop", 64'(drop_cnt), 64'd1);
        chk("t2_level63", 64'(level), 64'd63);
        chk("t2_head", 64'(m_data), 64'h0000_0100);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        m_ready = 1'b0;
        chk("t2_level57", 64'(level), 64'd57);
        do_dump(16'h0109, 32'h1000_0900, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        chk("t2_level64", 64'(level), 64'd64);
        chk("t2_full_valid", 64'(m_valid), 64'd1);
        chk("t2_full_head", 64'({m_last, m_data}), 64'({1'b1, 32'h1000_0005}));
        chk("t2_drop_keep", 64'(drop_cnt), 64'd1);
        m_ready = 1'b1;
        wait_q("t2", 70);
        cmp_q("t2_stream");
        chk("t2_drained", 64'(level), 64'd0);

        // 3: dump while busy dropped; dump right after return to IDLE accepted
        do_reset();
        m_ready = 1'b1;
        do_dump(16'h0011, 32'hB000_0000, 1'b1);
        tick(); tick();
        do_dump(16'h0022, 32'hBB00_0000, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        do_dump(16'h0033, 32'hC000_0000, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        do_dump(16'h0044, 32'hCC00_0000, 1'b0);
        wait_q("t3", 14);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        chk("t3_irq", 64'(irq_n), 64'd2);
        cmp_q("t3_stream");

        // 4: random backpressure, ordering and stall stability
        do_reset();
        stab_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            m_ready = ($urandom_range(0, 99) < 30);
            if (c % 8 == 0 && c < 40) begin
                set_iq(16'h4000 + 16'(c), 32'hD000_0000 + (32'(c) << 8));
                dump = 1'b1;
                exp_frame(16'h4000 + 16'(c), 32'hD000_0000 + (32'(c) << 8));
            end
            tick();
            dump = 1'b0;
        end
        m_ready = 1'b1;
        wait_q("t4", 35);
        stab_en = 1'b0;
        cmp_q("t4_stream");
        chk("t4_drop", 64'(drop_cnt), 64'd0);

        // 5: clear mid-frame with a simultaneous dump
        do_reset();
        m_ready = 1'b1;
        do_dump(16'h0055, 32'hE000_0000, 1'b0);
        tick(); tick();
        clear = 1'b1;
        set_iq(16'h0077, 32'hEE00_0000);
        dump = 1'b1;
        tick();
        clear = 1'b0;
        dump = 1'b0;
        irq_n = 0;
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_valid", 64'(m_valid), 64'd0);
        chk("t5_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_noirq", 64'(irq_n), 64'd0);
        chk("t5_still_empty", 64'(m_valid), 64'd0);
        got.delete();
        mseq = 8'd0;
        do_dump(16'h0066, 32'hF000_0000, 1'b1);
        wait_q("t5", 7);
        cmp_q("t5_stream");
        chk("t5_irq1", 64'(irq_n), 64'd1);

        // 6: seq wrap over 257 frames, then drop counter saturation
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            do_dump(16'(i), 32'h2000_0000 + (32'(i) << 8), 1'b1);
            for (int j = 0; j < 7; j++) tick();
        end
        wait_q("t6", 257 * 7);
        cmp_q("t6_stream");
        chk("t6_hdr255", 64'(got[255*7]), 64'({1'b0, 8'hFF, 8'h00, 16'd255}));
        chk("t6_hdr256", 64'(got[256*7]), 64'({1'b0, 8'h00, 8'h00, 16'd256}));
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_dump(16'h0, 32'h0, 1'b0);
            for (int j = 0; j < 7; j++) tick();
        end
        chk("t6_level63", 64'(level), 64'd63);
        dump = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        dump = 1'b0;
        tick();
        chk("t6_drop_sat", 64'(drop_cnt), 64'hFFFF);
        chk("t6_level_keep", 64'(level), 64'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
